// File: rtl/flodispatch_if.sv
// Command-side and flobuffer-side signal bundle for the flodispatch router.
interface flodispatch_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16,
    parameter int DLY_W  = 7
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic [CH_W-1:0]          cmd_ch_i;
    logic [DATA_W-1:0]        cmd_data_i;
    logic [DLY_W-1:0]         cmd_delay_i;
    logic                     cmd_direct_i;
    logic [N_CH*DATA_W-1:0]   fb_data_o;
    logic [N_CH*DLY_W-1:0]    fb_delay_o;
    logic [N_CH-1:0]          fb_valid_o;
    logic [N_CH-1:0]          fb_direct_o;
    logic [N_CH-1:0]          fb_full_i;
    logic [N_CH-1:0]          fb_empty_i;
    logic [N_CH-1:0]          fb_err_i;

    modport slave (
        input  cmd_valid_i, cmd_ch_i, cmd_data_i, cmd_delay_i, cmd_direct_i,
        input  fb_full_i, fb_empty_i, fb_err_i,
        output cmd_ready_o, fb_data_o, fb_delay_o, fb_valid_o, fb_direct_o
    );

    modport master (
        output cmd_valid_i, cmd_ch_i, cmd_data_i, cmd_delay_i, cmd_direct_i,
        output fb_full_i, fb_empty_i, fb_err_i,
        input  cmd_ready_o, fb_data_o, fb_delay_o, fb_valid_o, fb_direct_o
    );
endinterface

// File: rtl/flodispatch.sv
// Routes one timed-word command stream to N_CH flobuffers with per-channel
// full stalling, minimum write spacing and a sticky aggregated error.
module flodispatch #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16,
    parameter int DLY_W  = 7,
    parameter int WR_GAP = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  clr_err_i,
    flodispatch_if.slave          bus,
    output logic                  idle_o,
    output logic                  err_o,
    output logic [$clog2(N_CH):0] err_ch_o,
    output logic [15:0]           stall_cnt_o
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ERR_W = $clog2(N_CH) + 1;
    localparam logic [3:0] GAP_LOAD = 4'(WR_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t                 state_r;
    logic                   hold_v_r;
    logic [CH_W-1:0]        hold_ch_r;
    logic [DATA_W-1:0]      hold_data_r;
    logic [DLY_W-1:0]       hold_delay_r;
    logic                   hold_direct_r;
    logic [3:0]             gap_r [N_CH];
    logic [N_CH*DATA_W-1:0] fb_data_r;
    logic [N_CH*DLY_W-1:0]  fb_delay_r;
    logic [N_CH-1:0]        fb_valid_r;
    logic [N_CH-1:0]        fb_direct_r;
    logic                   err_r;
    logic [ERR_W-1:0]       err_ch_r;
    logic [15:0]            stall_cnt_r;

    logic                   active_s;
    logic                   issue_s;
    logic [N_CH-1:0]        issue_sel_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   bad_ch_s;
    logic                   stall_s;
    logic                   err_any_s;

    function automatic logic [ERR_W-1:0] lowest_set(input logic [N_CH-1:0] v);
        logic [ERR_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ERR_W'(i);
            end
        end
        return idx;
    endfunction

    // Issue decision, accept handshake and error detection for the current cycle
    always_comb begin
        active_s = (state_r == S_RUN) || (state_r == S_DRAIN);
        if (hold_v_r && active_s) begin
            if (hold_direct_r) begin
                issue_s = 1'b1;
            end else begin
                issue_s = !bus.fb_full_i[hold_ch_r] && (gap_r[hold_ch_r] == 4'd0);
            end
        end else begin
            issue_s = 1'b0;
        end
        if (issue_s) begin
            issue_sel_s = N_CH'(1) << hold_ch_r;
        end else begin
            issue_sel_s = '0;
        end
        ready_s   = (state_r == S_RUN) && (!hold_v_r || issue_s);
        accept_s  = bus.cmd_valid_i && ready_s;
        bad_ch_s  = accept_s && (32'(bus.cmd_ch_i) >= N_CH);
        stall_s   = hold_v_r && active_s && !issue_s;
        err_any_s = |bus.fb_err_i;
    end

    // Control FSM, hold register, per-channel gap counters and registered fb outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            hold_v_r      <= 1'b0;
            hold_ch_r     <= '0;
            hold_data_r   <= '0;
            hold_delay_r  <= '0;
            hold_direct_r <= 1'b0;
            fb_data_r     <= '0;
            fb_delay_r    <= '0;
            fb_valid_r    <= '0;
            fb_direct_r   <= '0;
            err_r         <= 1'b0;
            err_ch_r      <= '0;
            stall_cnt_r   <= 16'd0;
            for (int c = 0; c < N_CH; c++) begin
                gap_r[c] <= 4'd0;
            end
        end else begin
            // A channel's output slice only changes when that channel is written
            for (int c = 0; c < N_CH; c++) begin
                if (issue_sel_s[c]) begin
                    gap_r[c]                       <= GAP_LOAD;
                    fb_data_r[c*DATA_W +: DATA_W]  <= hold_data_r;
                    fb_delay_r[c*DLY_W +: DLY_W]   <= hold_delay_r;
                    fb_valid_r[c]                  <= !hold_direct_r;
                    fb_direct_r[c]                 <= hold_direct_r;
                end else begin
                    gap_r[c]       <= (gap_r[c] != 4'd0) ? (gap_r[c] - 4'd1) : 4'd0;
                    fb_valid_r[c]  <= 1'b0;
                    fb_direct_r[c] <= 1'b0;
                end
            end

            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end

            case (state_r)
                S_IDLE: begin
                    state_r <= enable_i ? S_RUN : S_IDLE;
                end
                S_RUN, S_DRAIN: begin
                    // A bad channel number is dropped rather than held
                    if (accept_s && !bad_ch_s) begin
                        hold_v_r      <= 1'b1;
                        hold_ch_r     <= bus.cmd_ch_i;
                        hold_data_r   <= bus.cmd_data_i;
                        hold_delay_r  <= bus.cmd_delay_i;
                        hold_direct_r <= bus.cmd_direct_i;
                    end else if (issue_s) begin
                        hold_v_r <= 1'b0;
                    end else begin
                        hold_v_r <= hold_v_r;
                    end

                    if (err_any_s) begin
                        state_r  <= S_ERR;
                        err_r    <= 1'b1;
                        err_ch_r <= lowest_set(bus.fb_err_i);
                    end else if (bad_ch_s) begin
                        state_r  <= S_ERR;
                        err_r    <= 1'b1;
                        err_ch_r <= ERR_W'(N_CH);
                    end else if ((state_r == S_RUN) && !enable_i) begin
                        state_r <= S_DRAIN;
                    end else if ((state_r == S_DRAIN) && !hold_v_r) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_ERR: begin
                    // A fresh overflow arriving with the clear re-arms the error
                    if (clr_err_i) begin
                        hold_v_r <= 1'b0;
                        if (err_any_s) begin
                            err_ch_r <= lowest_set(bus.fb_err_i);
                        end else begin
                            err_r    <= 1'b0;
                            err_ch_r <= '0;
                            state_r  <= S_IDLE;
                        end
                    end else begin
                        state_r <= S_ERR;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    hold_v_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = ready_s;
    assign bus.fb_data_o   = fb_data_r;
    assign bus.fb_delay_o  = fb_delay_r;
    assign bus.fb_valid_o  = fb_valid_r;
    assign bus.fb_direct_o = fb_direct_r;
    assign idle_o          = (state_r == S_IDLE) && !hold_v_r && (&bus.fb_empty_i);
    assign err_o           = err_r;
    assign err_ch_o        = err_ch_r;
    assign stall_cnt_o     = stall_cnt_r;
endmodule
